// File: rtl/tdpr_pkg.sv
// Shared constants and helpers for the byte-enable true dual-port RAM.
package tdpr_pkg;
    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    localparam int MERGE_W = 512;

    // Callers widen to MERGE_W and cast the result back to their word size.
    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_d,
        input logic [MERGE_W-1:0] new_d,
        input logic [MERGE_W-1:0] bit_mask
    );
        return (old_d & ~bit_mask) | (new_d & bit_mask);
    endfunction
endpackage

// File: rtl/tdpr_port_out.sv
// One port's output path: read-during-write select, optional
// output register and valid generation.
module tdpr_port_out
    import tdpr_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int BYTE_SIZE = 8,
    parameter int NB        = DATA_SIZE / BYTE_SIZE,
    parameter int RDW_MODE  = 0,
    parameter int OUT_REG   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NB-1:0]        we,
    input  logic [DATA_SIZE-1:0] old_word,
    input  logic [DATA_SIZE-1:0] din,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 vld
);
    logic [DATA_SIZE-1:0] wmask;
    logic [DATA_SIZE-1:0] merged;
    logic [DATA_SIZE-1:0] res_d;
    logic [DATA_SIZE-1:0] q1;
    logic                 res_v;
    logic                 wr;
    logic                 v1;

    for (genvar i = 0; i < NB; i++) begin : g_mask
        assign wmask[i*BYTE_SIZE +: BYTE_SIZE] = {BYTE_SIZE{we[i]}};
    end

    assign merged = DATA_SIZE'(byte_merge(MERGE_W'(old_word),
                                          MERGE_W'(din),
                                          MERGE_W'(wmask)));

    assign wr    = en && (|we);
    assign res_v = en && !(wr && RDW_MODE == RDW_NO_CHANGE);
    assign res_d = (wr && RDW_MODE == RDW_WRITE_FIRST) ? merged : old_word;

    // Data only loads on a valid result so idle cycles hold the last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= res_v;
            if (res_v) q1 <= res_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_SIZE-1:0] q2;
        logic                 v2;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q2 <= '0;
                v2 <= 1'b0;
            end else begin
                v2 <= v1;
                if (v1) q2 <= q1;
            end
        end
        assign dout = q2;
        assign vld  = v2;
    end else begin : g_noreg
        assign dout = q1;
        assign vld  = v1;
    end
endmodule

// File: rtl/tdpr_be_ram.sv
// True dual-port RAM with per-byte write enables, read-during-write
// modes, optional output register and write-write collision flag.
module tdpr_be_ram
    import tdpr_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 32,
    parameter int BYTE_SIZE = 8,
    parameter int RAM_SIZE  = 1 << ADDR_SIZE,
    parameter int RDW_MODE  = 0,
    parameter int OUT_REG   = 0,
    parameter int PRIO_A    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en_a,
    input  logic [DATA_SIZE/BYTE_SIZE-1:0] we_a,
    input  logic [ADDR_SIZE-1:0]           addr_a,
    input  logic [DATA_SIZE-1:0]           din_a,
    output logic [DATA_SIZE-1:0]           dout_a,
    output logic                           vld_a,
    input  logic                           en_b,
    input  logic [DATA_SIZE/BYTE_SIZE-1:0] we_b,
    input  logic [ADDR_SIZE-1:0]           addr_b,
    input  logic [DATA_SIZE-1:0]           din_b,
    output logic [DATA_SIZE-1:0]           dout_b,
    output logic                           vld_b,
    output logic                           coll
);
    localparam int NB = DATA_SIZE / BYTE_SIZE;

    logic [DATA_SIZE-1:0] mem [RAM_SIZE];
    logic [DATA_SIZE-1:0] old_a;
    logic [DATA_SIZE-1:0] old_b;
    logic [NB-1:0]        ovl;
    logic                 hit;
    logic                 coll_r;

    assign old_a = mem[addr_a];
    assign old_b = mem[addr_b];

    assign ovl = (en_a && en_b && addr_a == addr_b) ? (we_a & we_b) : '0;
    assign hit = |ovl;

    // The losing port drops only the overlapping lanes.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        always @(posedge clk) begin
            if (rst_n && en_a && we_a[i] && !(PRIO_A == 0 && ovl[i]))
                mem[addr_a][i*BYTE_SIZE +: BYTE_SIZE] <= din_a[i*BYTE_SIZE +: BYTE_SIZE];
        end
        always @(posedge clk) begin
            if (rst_n && en_b && we_b[i] && !(PRIO_A != 0 && ovl[i]))
                mem[addr_b][i*BYTE_SIZE +: BYTE_SIZE] <= din_b[i*BYTE_SIZE +: BYTE_SIZE];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) coll_r <= 1'b0;
        else        coll_r <= hit;
    end

    if (OUT_REG != 0) begin : g_coll_d
        logic coll_d;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) coll_d <= 1'b0;
            else        coll_d <= coll_r;
        end
        assign coll = coll_d;
    end else begin : g_coll
        assign coll = coll_r;
    end

    tdpr_port_out #(
        .DATA_SIZE(DATA_SIZE), .BYTE_SIZE(BYTE_SIZE), .NB(NB),
        .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)
    ) u_out_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .we(we_a),
        .old_word(old_a), .din(din_a), .dout(dout_a), .vld(vld_a)
    );

    tdpr_port_out #(
        .DATA_SIZE(DATA_SIZE), .BYTE_SIZE(BYTE_SIZE), .NB(NB),
        .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)
    ) u_out_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .we(we_b),
        .old_word(old_b), .din(din_b), .dout(dout_b), .vld(vld_b)
    );
endmodule

// File: tb/tb_tdpr_be_ram.sv
// Bench for tdpr_be_ram: three configurations share one stimulus
// stream and are compared with a word/byte-level reference model.
module tb_tdpr_be_ram;
    localparam int NC = 3;

    int mode_c [NC] = '{0, 1, 2};
    int oreg_c [NC] = '{0, 1, 0};
    int prio_c [NC] = '{1, 0, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic [3:0]  we_a = '0, we_b = '0;
    logic [7:0]  addr_a = '0, addr_b = '0;
    logic [31:0] din_a = '0, din_b = '0;
    logic [31:0] dout_a [NC];
    logic [31:0] dout_b [NC];
    logic        vld_a [NC];
    logic        vld_b [NC];
    logic        coll [NC];

    int n_checks = 0;
    int n_pass = 0;

    // reference state: memory, visible outputs, one-cycle delay line
    logic [31:0] mm   [NC][256];
    logic [31:0] ex_d [NC][2];
    logic        ex_v [NC][2];
    logic        ex_c [NC];
    logic [31:0] pd_d [NC][2];
    logic        pd_v [NC][2];
    logic        pd_c [NC];

    always #5 clk = ~clk;

    tdpr_be_ram #(.RDW_MODE(0), .OUT_REG(0), .PRIO_A(1)) u0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a[0]), .vld_a(vld_a[0]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b[0]), .vld_b(vld_b[0]), .coll(coll[0]));

    tdpr_be_ram #(.RDW_MODE(1), .OUT_REG(1), .PRIO_A(0)) u1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a[1]), .vld_a(vld_a[1]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b[1]), .vld_b(vld_b[1]), .coll(coll[1]));

    tdpr_be_ram #(.RDW_MODE(2), .OUT_REG(0), .PRIO_A(1)) u2 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(dout_a[2]), .vld_a(vld_a[2]),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(dout_b[2]), .vld_b(vld_b[2]), .coll(coll[2]));

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            ex_c[c] = 1'b0;
            pd_c[c] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                ex_d[c][p] = '0; ex_v[c][p] = 1'b0;
                pd_d[c][p] = '0; pd_v[c][p] = 1'b0;
            end
        end
    endtask

    // Advance one clock edge, updating the model from the current inputs.
    task automatic cycle();
        logic        en [2];
        logic [3:0]  we [2];
        logic [7:0]  ad [2];
        logic [31:0] dn [2];
        logic [31:0] old [2];
        logic [31:0] nw, rd;
        logic        rv, hit;
        int          lo, hi;
        en = '{en_a, en_b};
        we = '{we_a, we_b};
        ad = '{addr_a, addr_b};
        dn = '{din_a, din_b};
        if (rst_n) begin
            hit = en_a && en_b && addr_a == addr_b && (we_a & we_b) != 4'd0;
            for (int c = 0; c < NC; c++) begin
                for (int p = 0; p < 2; p++) old[p] = mm[c][ad[p]];
                for (int p = 0; p < 2; p++) begin
                    nw = old[p];
                    for (int l = 0; l < 4; l++)
                        if (we[p][l]) nw[8*l +: 8] = dn[p][8*l +: 8];
                    rv = en[p] && !(we[p] != 4'd0 && mode_c[c] == 2);
                    rd = (we[p] != 4'd0 && mode_c[c] == 1) ? nw : old[p];
                    if (oreg_c[c] != 0) begin
                        ex_v[c][p] = pd_v[c][p];
                        if (pd_v[c][p]) ex_d[c][p] = pd_d[c][p];
                        pd_v[c][p] = rv;
                        if (rv) pd_d[c][p] = rd;
                    end else begin
                        ex_v[c][p] = rv;
                        if (rv) ex_d[c][p] = rd;
                    end
                end
                if (oreg_c[c] != 0) begin
                    ex_c[c] = pd_c[c];
                    pd_c[c] = hit;
                end else begin
                    ex_c[c] = hit;
                end
                // lower-priority port writes first, winner overwrites
                lo = (prio_c[c] != 0) ? 1 : 0;
                hi = 1 - lo;
                for (int l = 0; l < 4; l++) begin
                    if (en[lo] && we[lo][l]) mm[c][ad[lo]][8*l +: 8] = dn[lo][8*l +: 8];
                    if (en[hi] && we[hi][l]) mm[c][ad[hi]][8*l +: 8] = dn[hi][8*l +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0;
    endtask

    task automatic test_reset();
        idle();
        #1 rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        for (int c = 0; c < NC; c++) begin
            n_checks++; if (dout_a[c] !== 32'h0) $display("FAIL rst_dout_a c%0d got %h exp 0", c, dout_a[c]); else n_pass++;
            n_checks++; if (dout_b[c] !== 32'h0) $display("FAIL rst_dout_b c%0d got %h exp 0", c, dout_b[c]); else n_pass++;
            n_checks++; if (vld_a[c] !== 1'b0) $display("FAIL rst_vld_a c%0d got %b exp 0", c, vld_a[c]); else n_pass++;
            n_checks++; if (vld_b[c] !== 1'b0) $display("FAIL rst_vld_b c%0d got %b exp 0", c, vld_b[c]); else n_pass++;
            n_checks++; if (coll[c] !== 1'b0) $display("FAIL rst_coll c%0d got %b exp 0", c, coll[c]); else n_pass++;
        end
        rst_n = 1'b1;
        cycle();
        cycle();
        for (int c = 0; c < NC; c++) begin
            n_checks++; if (dout_a[c] !== 32'h0 || vld_a[c] !== 1'b0 || coll[c] !== 1'b0)
                $display("FAIL post_rst_idle c%0d got %h/%b/%b exp 0/0/0", c, dout_a[c], vld_a[c], coll[c]);
            else n_pass++;
        end
    endtask

    task automatic test_byte_lanes();
        en_a = 1'b1; we_a = 4'b1111; addr_a = 8'h10; din_a = 32'h11223344;
        cycle();
        we_a = 4'b0101; din_a = 32'hAABBCCDD;
        cycle();
        idle();
        en_b = 1'b1; addr_b = 8'h10;
        cycle();
        idle();
        n_checks++; if (dout_b[0] !== 32'h11BB33DD) $display("FAIL lane_dout_b0 got %h exp 11bb33dd", dout_b[0]); else n_pass++;
        n_checks++; if (vld_b[0] !== 1'b1) $display("FAIL lane_vld_b0 got %b exp 1", vld_b[0]); else n_pass++;
        n_checks++; if (vld_b[1] !== 1'b0) $display("FAIL lane_vld_b1_early got %b exp 0", vld_b[1]); else n_pass++;
        cycle();
        n_checks++; if (dout_b[1] !== 32'h11BB33DD) $display("FAIL lane_dout_b1 got %h exp 11bb33dd", dout_b[1]); else n_pass++;
        n_checks++; if (vld_b[1] !== 1'b1) $display("FAIL lane_vld_b1 got %b exp 1", vld_b[1]); else n_pass++;
        n_checks++; if (vld_b[0] !== 1'b0) $display("FAIL lane_vld_b0_idle got %b exp 0", vld_b[0]); else n_pass++;
    endtask

    task automatic test_rdw_modes();
        en_a = 1'b1; we_a = 4'b1111; addr_a = 8'h20; din_a = 32'd5;
        cycle();
        we_a = 4'b0000;
        cycle();
        we_a = 4'b1111; din_a = 32'd9;
        cycle();
        idle();
        n_checks++; if (dout_a[0] !== 32'd5 || vld_a[0] !== 1'b1) $display("FAIL rdw_read_first got %h/%b exp 5/1", dout_a[0], vld_a[0]); else n_pass++;
        n_checks++; if (dout_a[2] !== 32'd5 || vld_a[2] !== 1'b0) $display("FAIL rdw_no_change got %h/%b exp 5/0", dout_a[2], vld_a[2]); else n_pass++;
        cycle();
        n_checks++; if (dout_a[1] !== 32'd9 || vld_a[1] !== 1'b1) $display("FAIL rdw_write_first got %h/%b exp 9/1", dout_a[1], vld_a[1]); else n_pass++;
    endtask

    task automatic test_collision();
        en_a = 1'b1; we_a = 4'b1111; addr_a = 8'h30; din_a = 32'h01020304;
        cycle();
        en_b = 1'b1; addr_b = 8'h30;
        we_a = 4'b1100; din_a = 32'hFFFF0000;
        we_b = 4'b0110; din_b = 32'h1234ABCD;
        cycle();
        idle();
        n_checks++; if (coll[0] !== 1'b1) $display("FAIL coll_pulse c0 got %b exp 1", coll[0]); else n_pass++;
        n_checks++; if (coll[1] !== 1'b0) $display("FAIL coll_delay c1 got %b exp 0", coll[1]); else n_pass++;
        en_a = 1'b1; addr_a = 8'h30;
        cycle();
        idle();
        n_checks++; if (coll[0] !== 1'b0) $display("FAIL coll_one_cycle c0 got %b exp 0", coll[0]); else n_pass++;
        n_checks++; if (coll[1] !== 1'b1) $display("FAIL coll_pulse c1 got %b exp 1", coll[1]); else n_pass++;
        n_checks++; if (dout_a[0] !== 32'hFFFFAB04) $display("FAIL coll_prio_a got %h exp ffffab04", dout_a[0]); else n_pass++;
        cycle();
        n_checks++; if (dout_a[1] !== 32'hFF34AB04) $display("FAIL coll_prio_b got %h exp ff34ab04", dout_a[1]); else n_pass++;
        n_checks++; if (coll[1] !== 1'b0) $display("FAIL coll_one_cycle c1 got %b exp 0", coll[1]); else n_pass++;
        en_a = 1'b1; en_b = 1'b1; addr_a = 8'h30; addr_b = 8'h30;
        we_a = 4'b1000; din_a = 32'h77000000;
        we_b = 4'b0001; din_b = 32'h00000099;
        cycle();
        idle();
        n_checks++; if (coll[0] !== 1'b0) $display("FAIL coll_disjoint c0 got %b exp 0", coll[0]); else n_pass++;
        cycle();
        n_checks++; if (coll[1] !== 1'b0) $display("FAIL coll_disjoint c1 got %b exp 0", coll[1]); else n_pass++;
        en_a = 1'b1; addr_a = 8'h30;
        cycle();
        idle();
        n_checks++; if (dout_a[0] !== 32'h77FFAB99) $display("FAIL coll_disjoint_data got %h exp 77ffab99", dout_a[0]); else n_pass++;
        cycle();
    endtask

    task automatic test_cross_port();
        en_a = 1'b1; we_a = 4'b1111; addr_a = 8'h40; din_a = 32'd7;
        cycle();
        we_a = 4'b0000;
        en_b = 1'b1; we_b = 4'b1111; addr_b = 8'h40; din_b = 32'd8;
        cycle();
        idle();
        n_checks++; if (dout_a[0] !== 32'd7) $display("FAIL xport_old got %h exp 7", dout_a[0]); else n_pass++;
        en_a = 1'b1; addr_a = 8'h40;
        cycle();
        idle();
        n_checks++; if (dout_a[0] !== 32'd8) $display("FAIL xport_new got %h exp 8", dout_a[0]); else n_pass++;
        n_checks++; if (dout_a[1] !== 32'd7) $display("FAIL xport_old_oreg got %h exp 7", dout_a[1]); else n_pass++;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            en_a = 1'b1; we_a = 4'b1111; addr_a = 8'(8'h80 + i); din_a = $urandom;
            cycle();
        end
        idle();
        cycle();
        for (int n = 0; n < 300; n++) begin
            en_a = 1'($urandom); en_b = 1'($urandom);
            we_a = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0;
            we_b = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'd0;
            addr_a = 8'(8'h80 + $urandom_range(0, 3));
            addr_b = 8'(8'h80 + $urandom_range(0, 3));
            din_a = $urandom; din_b = $urandom;
            cycle();
            for (int c = 0; c < NC; c++) begin
                n_checks++;
                if (dout_a[c] !== ex_d[c][0] || vld_a[c] !== ex_v[c][0])
                    $display("FAIL rnd_a c%0d n%0d got %h/%b exp %h/%b", c, n, dout_a[c], vld_a[c], ex_d[c][0], ex_v[c][0]);
                else n_pass++;
                n_checks++;
                if (dout_b[c] !== ex_d[c][1] || vld_b[c] !== ex_v[c][1])
                    $display("FAIL rnd_b c%0d n%0d got %h/%b exp %h/%b", c, n, dout_b[c], vld_b[c], ex_d[c][1], ex_v[c][1]);
                else n_pass++;
                n_checks++;
                if (coll[c] !== ex_c[c])
                    $display("FAIL rnd_coll c%0d n%0d got %b exp %b", c, n, coll[c], ex_c[c]);
                else n_pass++;
            end
        end
        idle();
        cycle();
        cycle();
    endtask

    task automatic test_mid_reset();
        en_a = 1'b1; we_a = 4'b0000; addr_a = 8'h10;
        cycle();
        idle();
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (vld_a[1] !== 1'b0 || dout_a[1] !== 32'h0) $display("FAIL midrst_now got %h/%b exp 0/0", dout_a[1], vld_a[1]); else n_pass++;
        cycle();
        n_checks++; if (vld_a[1] !== 1'b0 || dout_a[1] !== 32'h0) $display("FAIL midrst_hold got %h/%b exp 0/0", dout_a[1], vld_a[1]); else n_pass++;
        en_a = 1'b1; we_a = 4'b1111; addr_a = 8'h10; din_a = 32'hDEADBEEF;
        cycle();
        rst_n = 1'b1;
        we_a = 4'b0000;
        cycle();
        idle();
        n_checks++; if (vld_a[1] !== 1'b0) $display("FAIL midrst_no_vld got %b exp 0", vld_a[1]); else n_pass++;
        n_checks++; if (dout_a[0] !== 32'h11BB33DD) $display("FAIL midrst_write_blocked got %h exp 11bb33dd", dout_a[0]); else n_pass++;
        cycle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_byte_lanes();
        test_rdw_modes();
        test_collision();
        test_cross_port();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tdpr_be_ram.md
# tdpr_be_ram

Parametrised true dual-port RAM with per-byte write enables, a selectable read-during-write mode, an optional output register stage and write-collision detection. It succeeds the plain 8x256 dual-port RAM as the team's general on-chip buffer. Both ports are fully independent read/write ports on one clock. It serves as the shared scratch memory between two masters, for example a DMA engine and a core.

## Interface
- ADDR_SIZE, 8, address width per port
- DATA_SIZE, 32, word width; must be a multiple of BYTE_SIZE
- BYTE_SIZE, 8, width of one write-enable lane; NB = DATA_SIZE/BYTE_SIZE
- RAM_SIZE, 1 << ADDR_SIZE, number of words
- RDW_MODE, 0, same-port read-during-write: 0 read-first, 1 write-first, 2 no-change
- OUT_REG, 0, 0 = 1-cycle read latency, 1 = extra output register (2-cycle)
- PRIO_A, 1, 1 = port A wins write-write collisions, 0 = port B wins

Reset is asynchronous, active-low. Clock and reset ports, in order:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en_a  in  1  port A access enable
- we_a  in  NB  port A byte write enables (valid only with en_a)
- addr_a  in  ADDR_SIZE  port A address
- din_a  in  DATA_SIZE  port A write data
- dout_a  out  DATA_SIZE  port A read data
- vld_a  out  1  dout_a holds the result of a completed access
- en_b, we_b, addr_b, din_b, dout_b, vld_b: same as port A, for port B
- coll  out  1  write-write collision pulse

## Operation
- Access: en_x=1 at a rising edge. we_x==0 is a read. Any we_x bit set is a write of the selected lanes. Unselected lanes are unchanged.
- Port output per RDW_MODE, for the same port:
  - Read: dout_x = stored word.
  - Write, mode 0: dout_x = word before the write.
  - Write, mode 1: dout_x = merged word (new bytes in enabled lanes, old bytes elsewhere).
  - Write, mode 2: dout_x holds its previous value and vld_x stays 0 for that access.
- en_x=0: dout_x holds its value and vld_x=0.
- Cross-port read/write, same address, same cycle: the reading port returns the old word in every mode. The write still lands.
- Cross-port write/write, same address, overlapping lanes:
  - The priority port's bytes are stored in the overlapping lanes.
  - Non-overlapping lanes from both ports are stored.
  - coll pulses high for exactly one cycle.
- Write/write to the same address with disjoint lanes: both write, and coll stays 0.
- Memory contents are not reset, and reads of never-written words return X in simulation.
- Reset clears dout_a/b, vld_a/b, coll and all pipeline registers.

## Timing
- Reset values: dout_a = dout_b = 0, vld_a = vld_b = 0, coll = 0.
- Read latency: access at edge N gives dout/vld at edge N+1 when OUT_REG=0, or N+2 when OUT_REG=1.
- Throughput: one access per port per cycle with no stalls. vld is a per-cycle qualifier, not a handshake.
- A write at edge N is visible to a read from either port issued at edge N+1.
- coll registers at the colliding edge N, so it is high for N+1 to N+2. With OUT_REG=1 it is delayed one more cycle so it stays aligned with vld.
- Reset asserted mid-access:
  - In-flight results are discarded and outputs go to reset values immediately.
  - A write at an edge coinciding with rst_n=0 is not performed.
  - The first access is accepted at the first edge with rst_n=1.

## Structure
- Package tdpr_pkg holds the RDW_MODE constants (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2) and a function for the byte-merge of old and new data under a lane mask.
- Memory array: a single reg array written from two always blocks under clk, with the lane loop generated for NB lanes.
- Sub-module tdpr_port_out handles one port's output path: the RDW mux, the optional OUT_REG stage and vld generation. It is instantiated once per port.
- Collision compare (address equality AND lane overlap) is local logic in the top module.

## Test plan
- Reset then idle: rst_n=0 → dout_a = dout_b = 0 and vld = coll = 0. Release rst_n → outputs stay 0 until the first enabled access.
- Byte-lane write:
  - A writes 0x11223344 to 0x10 with we_a=4'b1111.
  - A writes 0xAABBCCDD to 0x10 with we_a=4'b0101.
  - B reads 0x10 → 0x11BB33DD, vld_b one cycle later (OUT_REG=0) or two cycles later (OUT_REG=1).
- RDW modes, with 0x20 = 0x00000005 and A writing 0x00000009 to 0x20:
  - Mode 0: dout_a = 5 with vld_a=1.
  - Mode 1: dout_a = 9 with vld_a=1.
  - Mode 2: dout_a unchanged and vld_a=0.
- Collision with PRIO_A=1:
  - A writes 0xFFFF0000 with we 1100 and B writes 0x1234ABCD with we 0110, both to 0x30.
  - Result: 0x30 = 0xFFFFAB?? (lane 0 unchanged), and coll=1 for one cycle.
  - Repeat with disjoint lanes → coll=0.
- Cross-port read/write: 0x40 = 7. A reads 0x40 while B writes 8 to 0x40 → dout_a = 7. Next-cycle read returns 8.
- Mid-operation reset with OUT_REG=1: issue a read, then assert rst_n one cycle later → vld_a never rises for that read and dout_a = 0.
